ahb_sram_slave: RTL and testbench

AHB-Lite responder that terminates transfers issued by the team's AHB master onto a word-organised on-chip memory. It supports:
- a configurable number of wait states;
- byte, halfword and word writes with little-endian lane selection;
- the two-cycle ERROR response for illegal accesses.

It sits on the slave side of the bus, after the address decoder that produces HSEL.

---
 rtl/ahb_sram_slave_pkg.sv | 43 ++++
 rtl/ahb_sram_bank.sv | 30 +++
 rtl/ahb_sram_slave.sv | 122 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared AHB encodings and responder state for the SRAM slave
package util;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_t;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        RS_READY = 2'd0,
        RS_WAIT  = 2'd1,
        RS_ERR1  = 2'd2,
        RS_ERR2  = 2'd3
    } resp_state_t;

    // Size/alignment legality; the range check lives with the memory depth.
    function automatic logic illegal_access(input logic [2:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// rtl/ahb_sram_bank.sv - DEPTH x WIDTH word array with byte-enable write and asynchronous read
module ahb_sram_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                     HCLK,
    input  logic                     we,
    input  logic [WIDTH/8-1:0]       be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge HCLK) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite responder with wait states and two-cycle ERROR onto an SRAM bank
module ahb_sram_slave
    import util::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic             HREADY,
    input  logic [WIDTH-1:0] HADDR,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  trans_t           HTRANS,
    input  logic [2:0]       HBURST,
    input  logic [3:0]       HPROT,
    input  logic             HMASTLOCK,
    input  logic [WIDTH-1:0] HWDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [WIDTH-1:0] HRDATA
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    resp_state_t      state;
    logic [CW-1:0]    wait_cnt;
    logic             dp_write;
    logic             dp_read;
    logic [AW-1:0]    dp_idx;
    logic [1:0]       dp_off;
    logic [1:0]       dp_size;
    logic             accept;
    logic             addr_err;
    logic             mem_we;
    logic [NB-1:0]    mem_be;
    logic [WIDTH-1:0] mem_rdata;
    logic             unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

    assign accept   = HSEL && HREADY && (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);
    assign addr_err = illegal_access(HSIZE, HADDR[1:0]) || ((HADDR >> 2) >= WIDTH'(DEPTH));

    // READY and ERR2 both end a data phase, so both sample the next address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= RS_READY;
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
            wait_cnt  <= '0;
            dp_write  <= 1'b0;
            dp_read   <= 1'b0;
            dp_idx    <= '0;
            dp_off    <= '0;
            dp_size   <= '0;
        end else begin
            case (state)
                RS_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= RS_READY;
                        HREADYOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RS_ERR1: begin
                    state     <= RS_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_ERROR;
                end
                default: begin
                    state     <= RS_READY;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_OKAY;
                    dp_write  <= 1'b0;
                    dp_read   <= 1'b0;
                    if (accept) begin
                        dp_idx  <= HADDR[AW+1:2];
                        dp_off  <= HADDR[1:0];
                        dp_size <= HSIZE[1:0];
                        if (addr_err) begin
                            state     <= RS_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= RESP_ERROR;
                        end else begin
                            dp_write <= HWRITE;
                            dp_read  <= !HWRITE;
                            if (WAIT_STATES > 0) begin
                                state     <= RS_WAIT;
                                HREADYOUT <= 1'b0;
                                wait_cnt  <= WAIT_LOAD;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Write lands on the edge closing the OKAY data phase, so a following read sees it.
    assign mem_we = dp_write && (state == RS_READY);
    assign mem_be = NB'(lane_mask(dp_size, dp_off));
    assign HRDATA = dp_read ? mem_rdata : '0;

    ahb_sram_bank #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_bank (
        .HCLK  (HCLK),
        .we    (mem_we),
        .be    (mem_be),
        .idx   (dp_idx),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - scoreboard bench for ahb_sram_slave with one- and zero-wait instances
module tb_ahb_sram_slave;
    import util::*;

    typedef struct {
        bit          err;
        bit          is_read;
        logic [31:0] rdata;
    } exp_t;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic [1:0]  hsel    = 2'b00;
    logic [31:0] haddr   = '0;
    logic [31:0] hwdata  = '0;
    logic        hwrite  = 1'b0;
    logic [2:0]  hsize   = 3'd0;
    trans_t      htrans  = TRANS_IDLE;
    logic [1:0]  hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata0;
    logic [31:0] hrdata1;
    logic        hready_bus;
    resp_state_t st [2];

    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model_mem [2][16];
    bit          in_dp [2];
    int          cyc [2];
    exp_t        cur [2];
    logic [31:0] mon_rd;
    int          mon_ws;

    always #5 HCLK = ~HCLK;

    assign hready_bus = &hreadyout;
    assign st[0] = u_dut0.state;
    assign st[1] = u_dut1.state;

    ahb_sram_slave #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(1)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HREADY(hready_bus),
        .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HTRANS(htrans),
        .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0), .HWDATA(hwdata),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata0)
    );

    ahb_sram_slave #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HREADY(hready_bus),
        .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HTRANS(htrans),
        .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0), .HWDATA(hwdata),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: follows each slave's data phases and compares against queued expectations.
    always @(negedge HCLK) begin
        for (int d = 0; d < 2; d++) begin
            mon_rd = (d == 0) ? hrdata0 : hrdata1;
            mon_ws = (d == 0) ? 1 : 0;
            if (!HRESETn) begin
                in_dp[d] = 1'b0;
                if (d == 0) q0.delete(); else q1.delete();
                check("reset_hreadyout", 32'(hreadyout[d]), 32'd1);
                check("reset_hresp", 32'(hresp[d]), 32'd0);
                check("reset_hrdata", mon_rd, 32'd0);
            end else begin
                if (in_dp[d]) begin
                    cyc[d]++;
                    if (cur[d].err) begin
                        check("err_hreadyout", 32'(hreadyout[d]), (cyc[d] == 1) ? 32'd0 : 32'd1);
                        check("err_hresp", 32'(hresp[d]), 32'd1);
                        check("err_hrdata", mon_rd, 32'd0);
                        if (cyc[d] >= 2) in_dp[d] = 1'b0;
                    end else if (cyc[d] <= mon_ws) begin
                        check("wait_hreadyout", 32'(hreadyout[d]), 32'd0);
                        check("wait_hresp", 32'(hresp[d]), 32'd0);
                    end else begin
                        check("done_hreadyout", 32'(hreadyout[d]), 32'd1);
                        check("done_hresp", 32'(hresp[d]), 32'd0);
                        if (cur[d].is_read) check("read_hrdata", mon_rd, cur[d].rdata);
                        in_dp[d] = 1'b0;
                    end
                end else begin
                    check("idle_hreadyout", 32'(hreadyout[d]), 32'd1);
                    check("idle_hresp", 32'(hresp[d]), 32'd0);
                    check("idle_hrdata", mon_rd, 32'd0);
                    check("idle_state", 32'(st[d]), 32'(RS_READY));
                end
                if (hsel[d] && hready_bus && (htrans inside {TRANS_NONSEQ, TRANS_SEQ})) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_accept: dut%0d got a transfer with no expectation queued", d);
                    end else begin
                        cur[d]   = (d == 0) ? q0.pop_front() : q1.pop_front();
                        in_dp[d] = 1'b1;
                        cyc[d]   = 0;
                    end
                end
            end
        end
    end

    // Drives one address phase, queues its expected response, returns after it is sampled.
    task automatic drive(input int d, input bit sel, input trans_t tr, input logic [31:0] a,
                         input bit w, input logic [2:0] sz, input logic [31:0] wd, input bit commit);
        exp_t e;
        int   idx;
        int   off;
        int   nb;
        int   n;
        hsel   = sel ? 2'(1 << d) : 2'b00;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = tr;
        if (sel && (tr == TRANS_NONSEQ || tr == TRANS_SEQ)) begin
            idx       = int'(a >> 2);
            off       = int'(a % 4);
            nb        = (sz <= 3'd2) ? (1 << sz) : 1;
            e.err     = (sz > 3'd2) || ((off % nb) != 0) || (idx >= 256);
            e.is_read = !w;
            e.rdata   = '0;
            if (!e.err) begin
                if (w) begin
                    if (commit) begin
                        for (int b = off; b < off + nb; b++) model_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
                    end
                end else begin
                    e.rdata = model_mem[d][idx];
                end
            end
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(negedge HCLK);
        n = 0;
        while (!hready_bus && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL hready_timeout: got hready=%b expected 1 within 50 cycles", hready_bus);
        end
        @(posedge HCLK);
        #1;
        hwdata = wd;
    endtask

    initial begin
        trans_t      tr;
        logic [31:0] a;
        logic [2:0]  sz;
        int          d;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                drive(k, 1, TRANS_NONSEQ, 32'(i * 4), 1, SIZE_WORD, 32'h0, 1);

        drive(0, 1, TRANS_NONSEQ, 32'h10, 1, SIZE_WORD, 32'hDEADBEEF, 1);
        drive(0, 1, TRANS_SEQ,    32'h10, 0, SIZE_WORD, 32'h0, 1);
        drive(0, 1, TRANS_NONSEQ, 32'h21, 1, SIZE_BYTE, 32'h0000AA00, 1);
        drive(0, 1, TRANS_NONSEQ, 32'h20, 0, SIZE_WORD, 32'h0, 1);
        drive(0, 1, TRANS_NONSEQ, 32'h00, 1, SIZE_WORD, 32'h01020304, 1);
        drive(0, 1, TRANS_NONSEQ, 32'h03, 1, SIZE_HALF, 32'hFFFFFFFF, 1);
        drive(0, 1, TRANS_NONSEQ, 32'h00, 0, SIZE_WORD, 32'h0, 1);
        drive(0, 1, TRANS_NONSEQ, 32'h400, 0, SIZE_WORD, 32'h0, 1);
        drive(0, 1, TRANS_IDLE,   32'h00, 1, SIZE_WORD, 32'hBAD0BAD0, 1);
        drive(0, 1, TRANS_BUSY,   32'h00, 1, SIZE_WORD, 32'hBAD1BAD1, 1);
        drive(0, 0, TRANS_NONSEQ, 32'h00, 1, SIZE_WORD, 32'hBAD2BAD2, 1);
        drive(0, 1, TRANS_NONSEQ, 32'h00, 0, SIZE_WORD, 32'h0, 1);

        drive(1, 1, TRANS_NONSEQ, 32'h08, 1, SIZE_WORD, 32'h5, 1);
        drive(1, 1, TRANS_NONSEQ, 32'h08, 0, SIZE_WORD, 32'h0, 1);

        // master drops to IDLE while the error response is in progress
        drive(0, 1, TRANS_NONSEQ, 32'h06, 0, SIZE_WORD, 32'h0, 1);
        drive(0, 1, TRANS_IDLE,   32'h08, 0, SIZE_WORD, 32'h0, 1);
        drive(0, 1, TRANS_IDLE,   32'h08, 0, SIZE_WORD, 32'h0, 1);

        drive(0, 1, TRANS_NONSEQ, 32'h30, 1, SIZE_WORD, 32'h12345678, 0);
        HRESETn = 1'b0;
        hsel    = 2'b00;
        htrans  = TRANS_IDLE;
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        drive(0, 1, TRANS_NONSEQ, 32'h30, 0, SIZE_WORD, 32'h0, 1);

        for (int i = 0; i < 300; i++) begin
            d = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0:          tr = TRANS_IDLE;
                1:          tr = TRANS_BUSY;
                2, 3, 4, 5: tr = TRANS_NONSEQ;
                default:    tr = TRANS_SEQ;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h400 + $urandom_range(0, 1023);
            else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15)) << 2;
            else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            drive(d, $urandom_range(0, 19) != 0, tr, a, 1'($urandom_range(0, 1)), sz, $urandom, 1);
        end

        repeat (4) drive(0, 0, TRANS_IDLE, 32'h0, 0, SIZE_WORD, 32'h0, 1);
        check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
